// File: rtl/serial_addsub_if.sv
// Request/response bundle for the bit-serial adder/subtractor.
// Signal direction prefixes are from the arithmetic unit's point of view.
interface serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             i_start;
    logic             i_sub;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_s;
    logic             o_cout;
    logic             o_ovf;

    // Requester side: launches operations and consumes results.
    modport master (
        output i_start, i_sub, i_a, i_b,
        input  o_busy, o_done, o_s, o_cout, o_ovf
    );

    // Arithmetic unit side.
    modport slave (
        input  i_start, i_sub, i_a, i_b,
        output o_busy, o_done, o_s, o_cout, o_ovf
    );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: a single full-adder cell with a carry flop
// walks the operands LSB first, one bit per clock. Subtraction is A + ~B + 1
// by inverting B at load time and seeding the carry with 1.
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic           i_clk,
    input  logic           i_rst,
    serial_addsub_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_s;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_busy;
    logic             r_done;
    logic             r_cout;
    logic             r_ovf;

    // Full-adder cell on the current LSBs.
    wire w_sum  = r_a[0] ^ r_b[0] ^ r_carry;
    wire w_c    = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));
    // Bit now being summed is the MSB; r_carry is its carry-in.
    wire w_last = (r_cnt == CW'(WIDTH - 1));
    wire [WIDTH-1:0] w_res_next = {w_sum, r_res[WIDTH-1:1]};

    // Control FSM and datapath; all outputs are registered here.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_s     <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                // FIN is the last busy cycle; a START seen on its exit edge is
                // accepted directly so a held START yields one op per
                // WIDTH+1 cycles.
                IDLE, FIN: begin
                    r_done <= 1'b0;
                    if (bus.i_start) begin
                        r_a     <= bus.i_a;
                        r_b     <= bus.i_sub ? ~bus.i_b : bus.i_b;
                        r_carry <= bus.i_sub;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= SHIFT;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                SHIFT: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_res   <= w_res_next;
                    r_carry <= w_c;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_s     <= w_res_next;
                        r_cout  <= w_c;
                        r_ovf   <= r_carry ^ w_c;
                        r_done  <= 1'b1;
                        r_state <= FIN;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_busy = r_busy;
    assign bus.o_done = r_done;
    assign bus.o_s    = r_s;
    assign bus.o_cout = r_cout;
    assign bus.o_ovf  = r_ovf;
endmodule
